// File: rtl/ftdi_receiver_if.sv
// rtl/ftdi_receiver_if.sv - byte holding-register handshake between the FTDI receiver and its consumer
//
// Signals:
//   data           received byte, meaningful while data_valid=1
//   data_valid     holding register full
//   data_ack       consumer takes the byte (sampled on posedge clk)
//   ready_for_byte flow-control hint, always !data_valid
//
// master: the receiver (drives the byte), slave: the consumer (drives the ack).
interface ftdi_receiver_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       ready_for_byte;

    modport master (
        output data,
        output data_valid,
        output ready_for_byte,
        input  data_ack
    );

    modport slave (
        input  data,
        input  data_valid,
        input  ready_for_byte,
        output data_ack
    );
endinterface

// File: rtl/ftdi_receiver.sv
// rtl/ftdi_receiver.sv - UART 8N1 receiver for the FTDI host-to-FPGA line
//
// Deserialises bytes arriving on FTDI_TX using a free-running 16x
// oversampling phase accumulator and presents them in a one-byte holding
// register with a valid/ack handshake.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   FTDI_TX        serial line from the FTDI chip, idle high, asynchronous
//   byte_if        holding-register handshake (data, data_valid, data_ack,
//                  ready_for_byte), master side
//   framing_error  one-cycle pulse when the stop bit is sampled low
//   overrun        one-cycle pulse when a byte completes while the holding
//                  register is full and not being acknowledged
//   state_test     current FSM state encoding, for debug
module ftdi_receiver #(
    parameter longint unsigned FREQUENCY = 50_000_000,
    parameter longint unsigned BAUD_RATE = 115_200,
    parameter int              ACC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   FTDI_TX,
    ftdi_receiver_if.master        byte_if,
    output logic                   framing_error,
    output logic                   overrun,
    output logic [2:0]             state_test
);

    // Rounded phase increment for 16 ticks per bit; 64-bit arithmetic keeps
    // the shifted product from overflowing for realistic rates.
    localparam longint unsigned INC_WIDE =
        (((BAUD_RATE * 64'd16) << ACC_WIDTH) + (FREQUENCY / 64'd2)) / FREQUENCY;
    localparam logic [ACC_WIDTH:0] INCREMENT = INC_WIDE[ACC_WIDTH:0];

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; both flops reset high so a reset never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= FTDI_TX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Tick generator: the carry out of the accumulator is the tick. It runs
    // regardless of FSM state so tick phase is fixed relative to reset.
    // ------------------------------------------------------------------
    logic [ACC_WIDTH:0] acc_q;
    logic [ACC_WIDTH:0] acc_d;
    logic               tick;

    assign acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + INCREMENT;
    assign tick  = acc_q[ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t     state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q,   shift_d;
    logic       stop_good;
    logic       stop_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The tick that first sees the line low is the reference T0.
                if (tick && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (cnt_q == 4'd7) begin
                        // Mid start bit: still low confirms a real start,
                        // high means it was a glitch.
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    // The counter wraps 15 -> 0 on its own, which also leaves
                    // it cleared for the stop bit.
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (rx_s_q) begin
                            stop_good = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = S_WAIT_HIGH;
                        end
                    end
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) must go high before a new start
                // bit can be recognised.
                if (tick && rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and status pulses
    // ------------------------------------------------------------------
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       fe_q,    fe_d;
    logic       ov_q,    ov_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = stop_bad;
        ov_d    = 1'b0;

        if (stop_good) begin
            // An ack in the same cycle frees the register for the new byte.
            if (!valid_q || byte_if.data_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (byte_if.data_ack) begin
            valid_d = 1'b0;
        end
    end

    assign byte_if.data           = data_q;
    assign byte_if.data_valid     = valid_q;
    assign byte_if.ready_for_byte = !valid_q;
    assign framing_error          = fe_q;
    assign overrun                = ov_q;
    assign state_test             = state_q;

endmodule

// File: tb/tb_ftdi_receiver.sv
// tb/tb_ftdi_receiver.sv - self-checking bench for ftdi_receiver against a frame-level model
module tb_ftdi_receiver;
    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx;
    logic       fe;
    logic       ov;
    logic [2:0] st;
    logic       ack_req = 1'b0;
    logic       rand_ack = 1'b0;
    logic       rnd_ack = 1'b0;

    ftdi_receiver_if bif ();
    assign bif.data_ack = rand_ack ? rnd_ack : ack_req;

    ftdi_receiver #(
        .FREQUENCY (3_200_000),
        .BAUD_RATE (100_000),
        .ACC_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .FTDI_TX       (tx),
        .byte_if       (bif.master),
        .framing_error (fe),
        .overrun       (ov),
        .state_test    (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ack = ($urandom_range(0, 3) == 0);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame-level model: each queued frame resolves at one predicted cycle.
    typedef struct {
        int         e;
        bit         bad_stop;
        logic [7:0] b;
    } exp_t;

    exp_t       q[$];
    int         R = 0;
    bit         started = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       ack_prev = 1'b0;
    logic       rst_prev = 1'b0;
    logic       prev_dv = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         dv_rise_cyc = 0;

    // Line low after edge t0 reaches rx_s at edge t0+2; the first tick cycle
    // (ticks sit on cycles R+2, R+4, ...) seeing it is T0; the stop sample is
    // 152 ticks = 304 clk later and shows on the following edge.
    function automatic int ev_cycle(input int t0);
        int c0;
        c0 = t0 + 2;
        if (((c0 - R) % 2) != 0) c0++;
        return c0 + 305;
    endfunction

    always @(negedge clk) begin
        logic e_fe;
        logic e_ov;
        exp_t ent;
        if (rst_prev) begin
            R         = cyc;
            started   = 1;
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            q.delete();
            chk("rst_valid", 32'(bif.data_valid), 32'd0);
            chk("rst_data",  32'(bif.data), 32'd0);
            chk("rst_fe",    32'(fe), 32'd0);
            chk("rst_ov",    32'(ov), 32'd0);
            chk("rst_state", 32'(st), 32'd0);
        end else if (started) begin
            e_fe = 1'b0;
            e_ov = 1'b0;
            if (q.size() > 0 && q[0].e == cyc) begin
                ent = q.pop_front();
                if (ent.bad_stop) begin
                    e_fe = 1'b1;
                    if (ack_prev) exp_valid = 1'b0;
                end else if (!exp_valid || ack_prev) begin
                    exp_valid = 1'b1;
                    exp_data  = ent.b;
                end else begin
                    e_ov = 1'b1;
                end
            end else if (ack_prev) begin
                exp_valid = 1'b0;
            end
            chk("valid", 32'(bif.data_valid), 32'(exp_valid));
            chk("data",  32'(bif.data), 32'(exp_data));
            chk("ready", 32'(bif.ready_for_byte), 32'(!exp_valid));
            chk("framing_error", 32'(fe), 32'(e_fe));
            chk("overrun", 32'(ov), 32'(e_ov));
        end
        if (fe === 1'b1) fe_cnt++;
        if (ov === 1'b1) ov_cnt++;
        if (bif.data_valid === 1'b1 && prev_dv !== 1'b1) dv_rise_cyc = cyc;
        prev_dv  = bif.data_valid;
        ack_prev = bif.data_ack;
        rst_prev = reset;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int last_t0;

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int p,
                              input bit push, input int cut);
        logic [9:0] bits;
        exp_t       ent;
        int         n;
        bits    = {stop_ok, b, 1'b0};
        last_t0 = cyc;
        if (push) begin
            ent.e        = ev_cycle(cyc);
            ent.bad_stop = !stop_ok;
            ent.b        = b;
            q.push_back(ent);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tx = bits[i];
            for (int k = 0; k < p; k++) begin
                if (cut != 0 && n == cut) return;
                wait_cyc(1);
                n++;
            end
        end
    endtask

    task automatic pulse_ack();
        ack_req = 1'b1;
        wait_cyc(1);
        ack_req = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         t0;
        int         e;
        int         fe0;
        int         ov0;
        int         p;
        int         guard;
        bit         good;
        logic [7:0] b;

        reset = 1'b1;
        tx    = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        chk("init_data",  32'(bif.data), 32'h00);
        chk("init_valid", 32'(bif.data_valid), 32'd0);
        chk("init_ready", 32'(bif.ready_for_byte), 32'd1);
        chk("init_state", 32'(st), 32'd0);

        // 1: single byte after reset
        wait_cyc(5);
        send_frame(8'hA5, 1, BIT, 1, 0);
        t0 = last_t0;
        wait_cyc(20);
        chk("s1_data",    32'(bif.data), 32'h0000_00A5);
        chk("s1_valid",   32'(bif.data_valid), 32'd1);
        chk("s1_latency", 32'(dv_rise_cyc - t0 <= 310), 32'd1);
        chk("s1_fe_cnt",  32'(fe_cnt), 32'd0);
        chk("s1_ov_cnt",  32'(ov_cnt), 32'd0);
        chk("s1_state",   32'(st), 32'd0);
        pulse_ack();

        // 2: short glitch, then a real byte
        wait_cyc(10);
        t0 = cyc;
        tx = 1'b0;
        wait_cyc(6);
        tx = 1'b1;
        while (cyc < t0 + 21) wait_cyc(1);
        chk("s2_glitch_state", 32'(st), 32'd0);
        chk("s2_glitch_valid", 32'(bif.data_valid), 32'd0);
        send_frame(8'h3C, 1, BIT, 1, 0);
        wait_cyc(20);
        chk("s2_data", 32'(bif.data), 32'h0000_003C);
        pulse_ack();

        // 3: framing error, held-low line, recovery
        wait_cyc(10);
        fe0 = fe_cnt;
        send_frame(8'h3C, 0, BIT, 1, 0);
        wait_cyc(20);
        chk("s3_wait_high_state", 32'(st), 32'd4);
        chk("s3_no_valid", 32'(bif.data_valid), 32'd0);
        wait_cyc(44);
        tx = 1'b1;
        wait_cyc(10);
        chk("s3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("s3_idle", 32'(st), 32'd0);
        send_frame(8'h55, 1, BIT, 1, 0);
        wait_cyc(20);
        chk("s3_data",  32'(bif.data), 32'h0000_0055);
        chk("s3_valid", 32'(bif.data_valid), 32'd1);
        pulse_ack();

        // 4: back-to-back with no ack gives one overrun
        wait_cyc(10);
        ov0 = ov_cnt;
        send_frame(8'h01, 1, BIT, 1, 0);
        send_frame(8'hFF, 1, BIT, 1, 0);
        wait_cyc(20);
        chk("s4_data",    32'(bif.data), 32'h0000_0001);
        chk("s4_overrun", 32'(ov_cnt - ov0), 32'd1);
        ack_req = 1'b1;
        wait_cyc(1);
        ack_req = 1'b0;
        chk("s4_ack_valid", 32'(bif.data_valid), 32'd0);
        chk("s4_ack_ready", 32'(bif.ready_for_byte), 32'd1);
        wait_cyc(1);

        // 5: reset during bit 4 abandons the byte
        wait_cyc(10);
        send_frame(8'h80, 1, BIT, 0, 5 * BIT + BIT / 2);
        reset = 1'b1;
        tx    = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        chk("s5_state", 32'(st), 32'd0);
        chk("s5_valid", 32'(bif.data_valid), 32'd0);
        chk("s5_data",  32'(bif.data), 32'd0);
        chk("s5_ready", 32'(bif.ready_for_byte), 32'd1);
        wait_cyc(10);
        send_frame(8'h80, 1, BIT, 1, 0);
        wait_cyc(20);
        chk("s5_fresh_data", 32'(bif.data), 32'h0000_0080);
        pulse_ack();

        // 6: +/-3% bit period, second delivery acked in the same cycle
        wait_cyc(10);
        send_frame(8'h5A, 1, 33, 1, 0);
        wait_cyc(20);
        chk("s6_slow_data",  32'(bif.data), 32'h0000_005A);
        chk("s6_slow_valid", 32'(bif.data_valid), 32'd1);
        ov0 = ov_cnt;
        wait_cyc(4);
        e = ev_cycle(cyc);
        fork
            send_frame(8'h5A, 1, 31, 1, 0);
            begin
                while (cyc < e - 1) wait_cyc(1);
                ack_req = 1'b1;
                wait_cyc(1);
                ack_req = 1'b0;
            end
        join
        wait_cyc(10);
        chk("s6_fast_data",    32'(bif.data), 32'h0000_005A);
        chk("s6_fast_valid",   32'(bif.data_valid), 32'd1);
        chk("s6_no_overrun",   32'(ov_cnt - ov0), 32'd0);
        pulse_ack();

        // Randomised frames with random consumer acks
        rand_ack = 1'b1;
        for (int f = 0; f < 24; f++) begin
            b    = 8'($urandom);
            p    = 31 + int'($urandom_range(0, 2));
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, good, p, 1, 0);
            if (!good) begin
                wait_cyc(int'($urandom_range(0, 20)));
                tx = 1'b1;
                wait_cyc(8 + int'($urandom_range(0, 20)));
            end else begin
                wait_cyc(int'($urandom_range(0, 30)));
            end
        end
        rand_ack = 1'b0;

        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            wait_cyc(1);
            guard++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        wait_cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
